// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with two-entry skid buffer, flush and stall counter
module pipe_stage_skid #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 116,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nx;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic in_fire, out_fire, load_main_in, load_main_skid, load_skid;
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign out_ctrl  = out_valid ? main_ctrl : CTRL_BUBBLE;
  assign out_data  = main_data;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  // next state and entry load selects; flush kills everything including the incoming beat
  always_comb begin
    state_nx       = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) state_nx = EMPTY;
    else case (state)
      EMPTY: if (in_fire) begin
        state_nx     = ONE;
        load_main_in = 1'b1;
      end
      ONE: if (in_fire && out_fire) load_main_in = 1'b1;
        else if (in_fire) begin
          state_nx  = FULL;
          load_skid = 1'b1;
        end else if (out_fire) state_nx = EMPTY;
      FULL: if (out_fire) begin
        state_nx       = ONE;
        load_main_skid = 1'b1;
      end
      default: state_nx = EMPTY;
    endcase
  end
  // occupancy state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= EMPTY;
    else state <= state_nx;
  // main and skid payload registers; not cleared by flush
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      main_ctrl <= CTRL_BUBBLE;
      main_data <= '0;
      skid_ctrl <= CTRL_BUBBLE;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  // saturating count of stalled head cycles; clear wins over increment
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cnt <= '0;
    else if (stall_clr) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: randomized and directed checks against a queue-based reference model
module tb_pipe_stage_skid;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0, stall_clr = 0;
  logic [7:0] in_ctrl = 0;
  logic [15:0] in_data = 0;
  logic in_ready, out_valid;
  logic [7:0] out_ctrl;
  logic [15:0] out_data;
  logic [3:0] stall_cnt;
  int checks = 0, errors = 0;
  logic [23:0] q[$];
  int m_cnt = 0;
  logic [15:0] m_last = 0;

  pipe_stage_skid #(.CTRL_W(8), .DATA_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  // one clock with the reference model: a FIFO of capacity two whose head is the output
  task automatic step;
    bit inf, outf;
    inf = in_valid && q.size() < 2;
    outf = q.size() > 0 && out_ready;
    if (stall_clr) m_cnt = 0;
    else if (q.size() > 0 && !out_ready && m_cnt < 15) m_cnt++;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back({in_ctrl, in_data});
    end
    if (q.size() > 0) m_last = q[0][15:0];
    #1;
  endtask

  task automatic idle;
    in_valid = 0; flush = 0; stall_clr = 0; out_ready = 1;
    step(); step();
    stall_clr = 1; step(); stall_clr = 0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({out_valid, in_ready, out_ctrl, out_data, stall_cnt} !== {1'b0, 1'b1, 8'h00, 16'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset got v=%b r=%b c=%h d=%h s=%h", out_valid, in_ready, out_ctrl, out_data, stall_cnt);
    end
    @(negedge clk) rst = 1;
    step();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_streaming;
    idle();
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_ctrl = 8'(i); in_data = 16'(i);
      step();
      checks++;
      if ({out_valid, in_ready, out_data, stall_cnt} !== {1'b1, 1'b1, 16'(i), 4'h0}) begin
        errors++;
        $display("FAIL stream%0d got v=%b r=%b d=%h s=%h exp d=%h", i, out_valid, in_ready, out_data, stall_cnt, 16'(i));
      end
    end
    in_valid = 0;
  endtask

  task automatic test_backpressure;
    logic [15:0] exp_d[3];
    exp_d = '{16'h00A0, 16'h00B0, 16'h00C0};
    idle();
    out_ready = 0;
    in_valid = 1; in_ctrl = 8'h11; in_data = 16'h00A0; step();
    in_data = 16'h00B0; step();
    in_data = 16'h00C0; step();
    checks++;
    if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, 16'h00A0}) begin
      errors++;
      $display("FAIL bp_full got v=%b r=%b d=%h exp v=1 r=0 d=00a0", out_valid, in_ready, out_data);
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_data !== exp_d[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_order%0d got v=%b d=%h exp %h", i, out_valid, out_data, exp_d[i]);
      end
      step();
      if (i == 1) in_valid = 0;
    end
    checks++;
    if ({out_valid, stall_cnt} !== {1'b0, 4'h2}) begin
      errors++;
      $display("FAIL bp_stallcnt got v=%b s=%h exp v=0 s=2", out_valid, stall_cnt);
    end
  endtask

  task automatic test_flush;
    idle();
    out_ready = 0;
    in_valid = 1; in_ctrl = 8'hFF; in_data = 16'h1111; step();
    in_data = 16'h2222; step();
    checks++;
    if ({out_valid, in_ready, out_ctrl} !== {1'b1, 1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL flush_prefill got v=%b r=%b c=%h exp v=1 r=0 c=ff", out_valid, in_ready, out_ctrl);
    end
    flush = 1; in_data = 16'hDEAD; step();
    flush = 0;
    checks++;
    if ({out_valid, in_ready, out_ctrl} !== {1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL flush got v=%b r=%b c=%h exp v=0 r=1 c=00", out_valid, in_ready, out_ctrl);
    end
    in_valid = 0; out_ready = 1; step();
    checks++;
    if ({out_valid, out_ctrl} !== {1'b0, 8'h00} || out_data === 16'hDEAD) begin
      errors++;
      $display("FAIL flush_after got v=%b c=%h d=%h exp v=0 c=00", out_valid, out_ctrl, out_data);
    end
  endtask

  task automatic test_bubble;
    idle();
    in_valid = 0; in_ctrl = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({out_valid, out_ctrl} !== {1'b0, 8'h00}) begin
        errors++;
        $display("FAIL bubble%0d got v=%b c=%h exp v=0 c=00", i, out_valid, out_ctrl);
      end
    end
  endtask

  task automatic test_saturation;
    idle();
    out_ready = 0;
    in_valid = 1; in_data = 16'h5A5A; step();
    in_valid = 0;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (stall_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat got s=%h exp f", stall_cnt);
    end
    stall_clr = 1; step(); stall_clr = 0;
    checks++;
    if (stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL sat_clr got s=%h exp 0", stall_cnt);
    end
  endtask

  task automatic test_async_reset;
    idle();
    out_ready = 0;
    in_valid = 1; in_ctrl = 8'h33; in_data = 16'h7777; step();
    in_data = 16'h8888; step();
    in_valid = 0;
    #2 rst = 0;
    #1;
    checks++;
    if ({out_valid, out_ctrl, in_ready} !== {1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL async_rst got v=%b c=%h r=%b exp v=0 c=00 r=1", out_valid, out_ctrl, in_ready);
    end
    q.delete(); m_cnt = 0; m_last = 0;
    @(negedge clk) rst = 1;
    step();
    checks++;
    if ({in_ready, stall_cnt, out_data} !== {1'b1, 4'h0, 16'h0}) begin
      errors++;
      $display("FAIL async_release got r=%b s=%h d=%h exp r=1 s=0 d=0", in_ready, stall_cnt, out_data);
    end
  endtask

  task automatic test_random;
    logic [29:0] exp_v;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      stall_clr = ($urandom_range(0, 29) == 0);
      in_ctrl = 8'($urandom);
      in_data = 16'($urandom);
      step();
      exp_v = {q.size() > 0, q.size() < 2, q.size() > 0 ? q[0][23:16] : 8'h00, m_last, 4'(m_cnt)};
      checks++;
      if ({out_valid, in_ready, out_ctrl, out_data, stall_cnt} !== exp_v) begin
        errors++;
        $display("FAIL random%0d got %h exp %h", i, {out_valid, in_ready, out_ctrl, out_data, stall_cnt}, exp_v);
      end
    end
    flush = 0; stall_clr = 0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_saturation();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
